// File: rtl/framebuffer_mem_ctrl.sv
// Framebuffer memory controller for the ILI9341 display path.
// Holds a downscaled RGB565 frame (one 16-bit word per pixel) in a single-port synchronous RAM
// and serves byte-wide reads from the display controller. A one-word read cache returns the
// second byte of a pixel with latency 1. A pixel-writer port fills the frame, and a clear engine
// fills the whole frame with CLEAR_COLOR.
//
// Ports:
//   clk        system clock
//   reset      synchronous active-low reset
//   mem_req    byte read request (single-cycle pulse)
//   mem_addr   byte address; pixel = mem_addr>>1, mem_addr[0]=0 -> high byte, 1 -> low byte
//   mem_ready  one-cycle pulse, mem_out valid
//   mem_out    read data byte, held until the next response
//   wr_valid   pixel write request
//   wr_addr    pixel index to write
//   wr_data    RGB565 pixel data
//   wr_ready   write accepted when wr_valid && wr_ready
//   clear      pulse: fill the whole frame with CLEAR_COLOR
//   busy       high while a clear is in progress
module framebuffer_mem_ctrl #(
  parameter int unsigned NUM_PIXELS  = 4800,
  parameter int unsigned PIX_ADDR_W  = 13,
  parameter logic [15:0] CLEAR_COLOR = 16'h0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_req,
  input  logic [31:0]           mem_addr,
  output logic                  mem_ready,
  output logic [7:0]            mem_out,
  input  logic                  wr_valid,
  input  logic [PIX_ADDR_W-1:0] wr_addr,
  input  logic [15:0]           wr_data,
  output logic                  wr_ready,
  input  logic                  clear,
  output logic                  busy
);

  typedef enum logic [1:0] {StIdle, StRdMiss, StClear} state_e;

  localparam logic [PIX_ADDR_W-1:0] LastPix = PIX_ADDR_W'(NUM_PIXELS - 1);

  state_e                state_q, state_d;
  logic                  ret_clear_q, ret_clear_d;   // miss started from CLEAR
  logic                  clear_pend_q, clear_pend_d; // clear arrived while a read was served
  logic [PIX_ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic                  cache_vld_q, cache_vld_d;
  logic [PIX_ADDR_W-1:0] cache_idx_q, cache_idx_d;
  logic [15:0]           cache_word_q, cache_word_d;
  logic [PIX_ADDR_W-1:0] rd_idx_q, rd_idx_d;
  logic                  rd_lo_q, rd_lo_d;
  logic                  mem_ready_q, mem_ready_d;
  logic [7:0]            mem_out_q, mem_out_d;

  // RAM port signals
  logic                  ram_we, ram_re;
  logic [PIX_ADDR_W-1:0] ram_waddr, ram_addr;
  logic [15:0]           ram_wdata, ram_rdata;
  logic [15:0]           ram [NUM_PIXELS];

  logic [PIX_ADDR_W-1:0] pix;
  logic                  addr_oob, rd_accept, cache_hit, wr_in_range;

  assign pix         = mem_addr[PIX_ADDR_W:1];
  assign addr_oob    = (|mem_addr[31:PIX_ADDR_W+1]) ||
                       ({{(32-PIX_ADDR_W){1'b0}}, pix} >= NUM_PIXELS);
  // A request while a response is pending (mem_ready high) or in RD_MISS is dropped.
  assign rd_accept   = mem_req && !mem_ready_q && (state_q == StIdle || state_q == StClear);
  assign cache_hit   = cache_vld_q && (cache_idx_q == pix);
  assign wr_in_range = {{(32-PIX_ADDR_W){1'b0}}, wr_addr} < NUM_PIXELS;

  assign wr_ready  = reset && (state_q == StIdle) && !mem_req && !clear && !clear_pend_q;
  assign busy      = (state_q == StClear) || (state_q == StRdMiss && ret_clear_q);
  assign mem_ready = mem_ready_q;
  assign mem_out   = mem_out_q;
  assign ram_addr  = ram_we ? ram_waddr : pix;

  always_comb begin
    state_d      = state_q;
    ret_clear_d  = ret_clear_q;
    clear_pend_d = clear_pend_q;
    clr_cnt_d    = clr_cnt_q;
    cache_vld_d  = cache_vld_q;
    cache_idx_d  = cache_idx_q;
    cache_word_d = cache_word_q;
    rd_idx_d     = rd_idx_q;
    rd_lo_d      = rd_lo_q;
    mem_ready_d  = 1'b0;
    mem_out_d    = mem_out_q;
    ram_we       = 1'b0;
    ram_re       = 1'b0;
    ram_waddr    = wr_addr;
    ram_wdata    = wr_data;

    if (rd_accept) begin
      if (addr_oob) begin
        mem_ready_d = 1'b1;
        mem_out_d   = 8'h00;
      end else if (cache_hit) begin
        mem_ready_d = 1'b1;
        mem_out_d   = mem_addr[0] ? cache_word_q[7:0] : cache_word_q[15:8];
      end else begin
        ram_re      = 1'b1;
        rd_idx_d    = pix;
        rd_lo_d     = mem_addr[0];
        ret_clear_d = (state_q == StClear);
        state_d     = StRdMiss;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (mem_req && clear) begin
          clear_pend_d = 1'b1;
        end else if (!mem_req && (clear || clear_pend_q)) begin
          state_d      = StClear;
          clear_pend_d = 1'b0;
          clr_cnt_d    = '0;
          cache_vld_d  = 1'b0;
        end
        if (wr_valid && wr_ready && wr_in_range) begin
          ram_we = 1'b1;
        end
      end
      StRdMiss: begin
        cache_vld_d  = 1'b1;
        cache_idx_d  = rd_idx_q;
        cache_word_d = ram_rdata;
        mem_ready_d  = 1'b1;
        mem_out_d    = rd_lo_q ? ram_rdata[7:0] : ram_rdata[15:8];
        state_d      = ret_clear_q ? StClear : StIdle;
        if (clear && !ret_clear_q) begin
          clear_pend_d = 1'b1;
        end
      end
      StClear: begin
        // Reads own the RAM: stall on a request and on the cycle its response is out.
        if (!mem_req && !mem_ready_q) begin
          ram_we    = 1'b1;
          ram_waddr = clr_cnt_q;
          ram_wdata = CLEAR_COLOR;
          if (clr_cnt_q == LastPix) begin
            state_d = StIdle;
          end else begin
            clr_cnt_d = clr_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Write-through keeps the cached word coherent with the RAM.
    if (ram_we && cache_vld_q && (cache_idx_q == ram_waddr)) begin
      cache_word_d = ram_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= StIdle;
      ret_clear_q  <= 1'b0;
      clear_pend_q <= 1'b0;
      clr_cnt_q    <= '0;
      cache_vld_q  <= 1'b0;
      cache_idx_q  <= '0;
      cache_word_q <= 16'h0000;
      rd_idx_q     <= '0;
      rd_lo_q      <= 1'b0;
      mem_ready_q  <= 1'b0;
      mem_out_q    <= 8'h00;
    end else begin
      state_q      <= state_d;
      ret_clear_q  <= ret_clear_d;
      clear_pend_q <= clear_pend_d;
      clr_cnt_q    <= clr_cnt_d;
      cache_vld_q  <= cache_vld_d;
      cache_idx_q  <= cache_idx_d;
      cache_word_q <= cache_word_d;
      rd_idx_q     <= rd_idx_d;
      rd_lo_q      <= rd_lo_d;
      mem_ready_q  <= mem_ready_d;
      mem_out_q    <= mem_out_d;
    end
  end

  // Frame storage: single port, contents not reset.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[ram_addr] <= ram_wdata;
    end else if (ram_re) begin
      ram_rdata <= ram[ram_addr];
    end
  end

endmodule

// File: doc/framebuffer_mem_ctrl.md
Name: framebuffer_mem_ctrl

Overview:
- Framebuffer memory controller that replaces the mock memory feeding the ILI9341 display controller.
- Stores a downscaled RGB565 frame as 16-bit words and serves the display controller's byte-wide requests over the mem_req/mem_addr/mem_ready/mem_out handshake.
- A pixel-writer port fills the frame, with a bulk clear engine for initialisation.
- Keeps a one-word read cache so the second byte of each pixel returns with minimum latency.

Parameters:
- NUM_PIXELS, 4800, frame size in 16-bit pixels (80x60 after DOWNSCALE_SHIFT=2).
- PIX_ADDR_W, 13, pixel index width; must satisfy 2^PIX_ADDR_W >= NUM_PIXELS.
- CLEAR_COLOR, 16'h0000, RGB565 value written by the clear engine.

Ports:
- clk  in  1  system clock (12 MHz HFOSC).
- reset  in  1  synchronous, active-low reset; the block resets on any rising clk edge where reset==0.
- mem_req  in  1  byte read request, single-cycle pulse per byte.
- mem_addr  in  32  byte address; pixel = mem_addr>>1; mem_addr[0]=0 selects high byte [15:8], 1 selects low byte [7:0].
- mem_ready  out  1  one-cycle pulse: mem_out valid.
- mem_out  out  8  read data byte.
- wr_valid  in  1  pixel write request.
- wr_addr  in  PIX_ADDR_W  pixel index to write.
- wr_data  in  16  RGB565 pixel data.
- wr_ready  out  1  write accepted on cycles where wr_valid && wr_ready.
- clear  in  1  pulse: fill whole frame with CLEAR_COLOR.
- busy  out  1  high while a clear is in progress.

Behaviour:
- Storage: NUM_PIXELS x 16 inferred synchronous RAM (BRAM/SPRAM), one port, one access per cycle; read data is available the cycle after the address is presented. Contents are not reset.
- Reset (reset==0): mem_ready=0, mem_out=8'h00, wr_ready=0, busy=0, cache invalid, clear counter=0, state IDLE. Reset mid-read or mid-clear aborts immediately; no mem_ready pulse is issued afterwards.
- States:
  - IDLE: accepts mem_req, writes and clear.
  - RD_MISS: RAM read issued, waiting for data.
  - CLEAR: one CLEAR_COLOR word written per cycle.
- Cache: a single entry holding a valid bit, a pixel index and a word.
- Read hit (IDLE or CLEAR, mem_req=1, cache valid, index == mem_addr>>1): mem_ready=1 and mem_out=selected byte on the next cycle; latency 1.
- Read miss:
  - Cycle 0: RAM read issued, go to RD_MISS.
  - Cycle 1: RAM data captured into the cache.
  - Cycle 2: mem_ready=1 and mem_out valid; latency 2. Return to the originating state (IDLE or CLEAR).
- Out-of-range read (mem_addr>>1 >= NUM_PIXELS, or mem_addr[31:PIX_ADDR_W+1] != 0): no RAM access; mem_out=8'h00, mem_ready next cycle; cache unchanged.
- mem_req asserted while a read is in flight (RD_MISS, or the cycle a response is pending) is ignored. The requester must wait for mem_ready.
- mem_ready is exactly one cycle and is never back-to-back with itself for a single request. mem_out holds its value until the next response.
- Write port:
  - wr_ready=1 only in IDLE when mem_req==0 and clear==0 (reads, then clear, have priority).
  - Accepted write: RAM written the same edge.
  - If wr_addr equals the cache index, the cache word is updated to wr_data the same edge, so there are no stale reads.
  - wr_addr >= NUM_PIXELS: accepted (handshake completes) and discarded.
- Clear:
  - A clear pulse in IDLE enters CLEAR: busy=1 on the next cycle, cache invalidated, counter=0.
  - Each cycle writes CLEAR_COLOR at the counter, then counter+1.
  - After writing index NUM_PIXELS-1, return to IDLE with busy=0 on the following cycle. Duration is NUM_PIXELS cycles plus any stalls.
  - In CLEAR, wr_ready=0 and clear pulses are ignored.
  - A mem_req in CLEAR takes priority: the clear stalls (no write that cycle, or for the whole miss sequence), the read is served normally, then the clear resumes at the same counter.
- Simultaneous events in IDLE:
  - mem_req and wr_valid: read served, wr_ready=0.
  - clear and wr_valid: clear starts, wr_ready=0.
  - mem_req and clear: read served, clear latched and started when the read completes.

Test Plan:
- Reset, then write pixel 5 = 16'hF800, then mem_req addr 10 -> mem_ready 2 cycles later with mem_out 8'hF8. Then addr 11 -> mem_ready 1 cycle later with 8'h00 (cache hit).
- Write pixel 5 = 16'h07E0 while pixel 5 is cached, then read addr 11 -> hit, 8'hE0 (no stale 8'h00).
- CLEAR_COLOR=16'h001F, pulse clear -> busy high for exactly 4800 cycles, wr_ready=0 throughout. Afterwards reads of addr 0/1 and 9598/9599 return 8'h00/8'h1F.
- During clear, issue a mem_req at counter=100 for addr 400 (pixel 200) -> returns pre-clear data, busy extends by the miss stall of 3 cycles, and the clear completes all 4800 pixels.
- mem_req and wr_valid in the same cycle -> read answered, wr_ready=0 that cycle, and the write is accepted the next cycle. A read at addr 9600 returns 8'h00 after 1 cycle.
- Assert reset (0) during RD_MISS and mid-clear -> no mem_ready pulse, busy=0, wr_ready=0 on the next edge. The first read after reset is a miss (latency 2).
